// File: rtl/alu_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// alu_pipe_skid_reg
// Two-entry skid-buffered pipeline register that carries an ALU operation
// bundle {a, b, c, op, inv} from an upstream valid/ready source to a
// downstream valid/ready sink. in_ready_o comes straight from a flop, so no
// combinational path exists from out_ready_i back to in_ready_o.
//
// Ports
//   clk_i          clock, rising edge
//   async_reset_i  asynchronous reset, active-low
//   flush_i        synchronous flush, active-high (highest priority)
//   in_valid_i     upstream offers a bundle
//   in_ready_o     block accepts a bundle this cycle (registered)
//   a_i, b_i       operands, WIDTH bits
//   c_i            carry-in
//   op_i           operation select, OPW bits
//   inv_i          invert-operand control
//   out_valid_o    output bundle valid (registered)
//   out_ready_i    downstream accepts the output bundle
//   a_o, b_o, c_o, op_o, inv_o   registered bundle toward the ALU
//   occupancy_o    stored entries, 0..2 (registered)
// ---------------------------------------------------------------------------
module alu_pipe_skid_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 3
) (
  input  logic             clk_i,
  input  logic             async_reset_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  input  logic [OPW-1:0]   op_i,
  input  logic             inv_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             c_o,
  output logic [OPW-1:0]   op_o,
  output logic             inv_o,
  output logic [1:0]       occupancy_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       occ_q, occ_d;

  // Output register entry
  logic [WIDTH-1:0] a_q, b_q;
  logic             c_q, inv_q;
  logic [OPW-1:0]   op_q;

  // Skid register entry
  logic [WIDTH-1:0] skid_a_q, skid_b_q;
  logic             skid_c_q, skid_inv_q;
  logic [OPW-1:0]   skid_op_q;

  logic accept_c;
  logic pop_c;
  logic load_out_c;
  logic load_skid_c;
  logic from_skid_c;

  assign accept_c = in_valid_i & in_ready_q;
  assign pop_c    = out_valid_q & out_ready_i;

  // State register
  always_ff @(posedge clk_i or negedge async_reset_i) begin
    if (!async_reset_i) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occ_q       <= occ_d;
    end
  end

  // Next-state, handshake flags and data-path enables
  always_comb begin
    state_d     = state_q;
    load_out_c  = 1'b0;
    load_skid_c = 1'b0;
    from_skid_c = 1'b0;

    if (flush_i) begin
      // Flush drops everything, including a same-cycle accept; data holds.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept_c) begin
            load_out_c = 1'b1;
            state_d    = ONE;
          end
        end
        ONE: begin
          if (accept_c && pop_c) begin
            load_out_c = 1'b1;
          end else if (accept_c) begin
            load_skid_c = 1'b1;
            state_d     = FULL;
          end else if (pop_c) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop_c) begin
            load_out_c  = 1'b1;
            from_skid_c = 1'b1;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
    occ_d       = 2'(state_d);
  end

  // Output and skid data registers
  always_ff @(posedge clk_i or negedge async_reset_i) begin
    if (!async_reset_i) begin
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= 1'b0;
      op_q       <= '0;
      inv_q      <= 1'b0;
      skid_a_q   <= '0;
      skid_b_q   <= '0;
      skid_c_q   <= 1'b0;
      skid_op_q  <= '0;
      skid_inv_q <= 1'b0;
    end else begin
      if (load_out_c) begin
        if (from_skid_c) begin
          a_q   <= skid_a_q;
          b_q   <= skid_b_q;
          c_q   <= skid_c_q;
          op_q  <= skid_op_q;
          inv_q <= skid_inv_q;
        end else begin
          a_q   <= a_i;
          b_q   <= b_i;
          c_q   <= c_i;
          op_q  <= op_i;
          inv_q <= inv_i;
        end
      end
      if (load_skid_c) begin
        skid_a_q   <= a_i;
        skid_b_q   <= b_i;
        skid_c_q   <= c_i;
        skid_op_q  <= op_i;
        skid_inv_q <= inv_i;
      end
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign occupancy_o = occ_q;
  assign a_o         = a_q;
  assign b_o         = b_q;
  assign c_o         = c_q;
  assign op_o        = op_q;
  assign inv_o       = inv_q;

endmodule

// File: tb/tb_alu_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe_skid_reg
// Directed and randomized self-checking bench for alu_pipe_skid_reg.
// Inputs change 1 time unit after each rising edge; outputs are sampled then.
// ---------------------------------------------------------------------------
module tb_alu_pipe_skid_reg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned OPW   = 3;
  localparam int unsigned BW    = 2 * WIDTH + OPW + 2;

  logic             clk_i = 1'b0;
  logic             async_reset_i;
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i, b_i;
  logic             c_i;
  logic [OPW-1:0]   op_i;
  logic             inv_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] a_o, b_o;
  logic             c_o;
  logic [OPW-1:0]   op_o;
  logic             inv_o;
  logic [1:0]       occupancy_o;

  int tests = 0;
  int fails = 0;

  alu_pipe_skid_reg #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk_i        (clk_i),
    .async_reset_i(async_reset_i),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .a_i          (a_i),
    .b_i          (b_i),
    .c_i          (c_i),
    .op_i         (op_i),
    .inv_i        (inv_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .a_o          (a_o),
    .b_o          (b_o),
    .c_o          (c_o),
    .op_o         (op_o),
    .inv_o        (inv_o),
    .occupancy_o  (occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] out_bundle();
    return {a_o, b_o, c_o, op_o, inv_o};
  endfunction

  task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic c, input logic [OPW-1:0] op, input logic inv);
    in_valid_i = v;
    a_i = a; b_i = b; c_i = c; op_i = op; inv_i = inv;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Status as a {out_valid, in_ready, occupancy} triple
  function automatic logic [BW-1:0] status();
    return BW'({out_valid_o, in_ready_o, occupancy_o});
  endfunction

  logic [BW-1:0] q[$];
  logic [BW-1:0] bun;
  logic          acc, pp;

  initial begin
    async_reset_i = 1'b0;
    flush_i       = 1'b0;
    out_ready_i   = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 3'h7, 1'b1);

    // Reset held while the upstream offers all-ones data
    tick(); tick();
    check("reset_status", status(), BW'(4'b0_1_00));
    check("reset_data",   out_bundle(), '0);
    async_reset_i = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    tick();
    check("post_reset_idle", status(), BW'(4'b0_1_00));

    // Streaming 1..8 with downstream always ready
    out_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, WIDTH'(i), WIDTH'(i * 16), 1'(i), OPW'(i), 1'(i >> 1));
      tick();
      check($sformatf("stream_a_%0d", i), BW'(a_o), BW'(i));
      check($sformatf("stream_status_%0d", i), status(), BW'(4'b1_1_01));
    end
    check("stream_last_bundle", out_bundle(),
          {32'd8, 32'd128, 1'b0, 3'd0, 1'b0});
    drive(1'b0, 32'h5555_5555, '0, 1'b0, '0, 1'b0);
    tick();
    check("stream_drain_status", status(), BW'(4'b0_1_00));
    check("stream_hold_data", BW'(a_o), BW'(8));

    // Skid fill with downstream stalled, then drain
    out_ready_i = 1'b0;
    drive(1'b1, 32'hA, 32'h1234, 1'b1, 3'd5, 1'b0);
    tick();
    check("skid_one_status", status(), BW'(4'b1_1_01));
    drive(1'b1, 32'hB, 32'h5678, 1'b0, 3'd2, 1'b1);
    tick();
    check("skid_full_status", status(), BW'(4'b1_0_10));
    check("skid_full_head", out_bundle(), {32'hA, 32'h1234, 1'b1, 3'd5, 1'b0});
    drive(1'b1, 32'hC, 32'h9999, 1'b1, 3'd7, 1'b1);
    tick();
    check("skid_stall_hold", out_bundle(), {32'hA, 32'h1234, 1'b1, 3'd5, 1'b0});
    check("skid_stall_status", status(), BW'(4'b1_0_10));
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    out_ready_i = 1'b1;
    tick();
    check("skid_pop1_bundle", out_bundle(), {32'hB, 32'h5678, 1'b0, 3'd2, 1'b1});
    check("skid_pop1_status", status(), BW'(4'b1_1_01));
    tick();
    check("skid_pop2_status", status(), BW'(4'b0_1_00));

    // Flush while FULL with a simultaneous offer
    out_ready_i = 1'b0;
    drive(1'b1, 32'h11, '0, 1'b0, '0, 1'b0); tick();
    drive(1'b1, 32'h22, '0, 1'b0, '0, 1'b0); tick();
    check("flush_pre_full", status(), BW'(4'b1_0_10));
    flush_i = 1'b1;
    in_valid_i = 1'b1;
    drive(1'b1, 32'h33, '0, 1'b0, '0, 1'b0);
    tick();
    check("flush_status", status(), BW'(4'b0_1_00));
    flush_i = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    out_ready_i = 1'b1;
    tick();
    check("flush_no_emit", status(), BW'(4'b0_1_00));
    check("flush_data_hold", BW'(a_o), BW'(32'h11));

    // Asynchronous reset between edges while FULL
    out_ready_i = 1'b0;
    drive(1'b1, 32'h44, 32'h1, 1'b1, 3'd1, 1'b1); tick();
    drive(1'b1, 32'h55, 32'h2, 1'b1, 3'd3, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    check("async_pre_full", status(), BW'(4'b1_0_10));
    #2;
    async_reset_i = 1'b0;
    #1;
    check("async_status", status(), BW'(4'b0_1_00));
    check("async_data", out_bundle(), '0);
    #1;
    async_reset_i = 1'b1;
    out_ready_i = 1'b1;
    tick();
    check("async_after_release", status(), BW'(4'b0_1_00));
    check("async_skid_cleared", out_bundle(), '0);

    // Randomized handshakes against a 2-deep FIFO model
    q.delete();
    for (int n = 0; n < 10000; n++) begin
      drive(1'($urandom), $urandom, $urandom, 1'($urandom), OPW'($urandom), 1'($urandom));
      out_ready_i = 1'($urandom);
      bun = {a_i, b_i, c_i, op_i, inv_i};
      if (q.size() != 0) begin
        check("rand_bundle", out_bundle(), q[0]);
      end
      check("rand_status", status(),
            BW'({q.size() != 0, q.size() < 2, 2'(q.size())}));
      acc = in_valid_i && (q.size() < 2);
      pp  = out_ready_i && (q.size() != 0);
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(bun);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_pipe_skid_reg.md
ALU_PIPE_SKID_REG -- requirements
Module: alu_pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits for a and b.
REQ-002 Parameter OPW, default 3, operation-code width in bits.
REQ-003 clk_i  input  1  clock; all state SHALL update on the rising edge.
REQ-004 async_reset_i  input  1  reset, asynchronous, active-low.
REQ-005 flush_i  input  1  synchronous flush, active-high.
REQ-006 in_valid_i  input  1  upstream holds a valid ALU operation.
REQ-007 in_ready_o  output  1  block accepts an operation this cycle.
REQ-008 a_i, b_i  input  WIDTH each  ALU operands.
REQ-009 c_i  input  1  carry-in.
REQ-010 op_i  input  OPW  operation select.
REQ-011 inv_i  input  1  invert-operand control.
REQ-012 out_valid_o  output  1  output bundle is valid.
REQ-013 out_ready_i  input  1  downstream accepts the output bundle.
REQ-014 a_o, b_o  output  WIDTH each; c_o output 1; op_o output OPW; inv_o output 1: registered bundle toward the ALU.
REQ-015 occupancy_o  output  2  stored entries, 0..2.

Function
REQ-016 Accept = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i; the bundle is {a, b, c, op, inv}, stored and forwarded unmodified.
REQ-017 The block SHALL hold two entries, an output register and a skid register, in states EMPTY (occupancy 0), ONE (1), and FULL (2).
REQ-018 in_ready_o SHALL be driven directly from a register: 1 in EMPTY and ONE, 0 in FULL, with no combinational path from out_ready_i.
REQ-019 out_valid_o SHALL be 1 in ONE and FULL, and 0 in EMPTY.
REQ-020 EMPTY: on accept, load the output register and go to ONE; otherwise stay in EMPTY.
REQ-021 ONE: on accept & pop, load the output register with the new bundle and stay in ONE.
REQ-022 ONE: on accept & !pop, load the skid register and go to FULL.
REQ-023 ONE: on pop & !accept, go to EMPTY; with neither, hold.
REQ-024 FULL: no accept is possible; on pop, move skid to the output register and go to ONE; otherwise hold.
REQ-025 Latency SHALL be 1 cycle: a bundle accepted at edge N appears on the outputs after edge N when the block was EMPTY.
REQ-026 Order SHALL be strictly FIFO, with no loss or duplication.
REQ-027 Throughput SHALL be one bundle per cycle while out_ready_i=1 and in_valid_i=1.
REQ-028 Output data SHALL remain stable while out_valid_o=1 and out_ready_i=0.
REQ-029 While out_valid_o=0, the data outputs SHALL hold their last value.
REQ-030 flush_i=1 SHALL go to EMPTY at the next edge, set in_ready_o=1, and discard any same-cycle accept; flush SHALL take priority over all other events.
REQ-031 occupancy_o SHALL equal the state encoding and be registered.

Reset
REQ-032 async_reset_i=0 SHALL immediately force EMPTY: out_valid_o=0, in_ready_o=1, occupancy_o=0, all data outputs and the skid register 0, regardless of the clock.
REQ-033 A reset asserted mid-transfer SHALL lose all stored bundles; operation SHALL resume on the first rising edge after release.

Verification
REQ-034 Reset with in_valid_i=1 and a_i=0xFFFFFFFF -> outputs all 0, out_valid_o=0, in_ready_o=1, occupancy_o=0.
REQ-035 Streaming a=1..8 with out_ready_i=1 -> a_o=1..8 on consecutive cycles, first at 1-cycle latency, in_ready_o constantly 1.
REQ-036 Send a=0xA then a=0xB with out_ready_i=0 -> occupancy_o=2, in_ready_o=0, a_o holds 0xA; release out_ready_i -> 0xA then 0xB, in_ready_o=1 after the first pop.
REQ-037 FULL state with flush_i=1 and in_valid_i=1 simultaneously -> next cycle occupancy_o=0, out_valid_o=0, the new bundle not emitted.
REQ-038 Random in_valid_i and out_ready_i over 10k cycles with a scoreboard -> zero mismatches, no drops, bundles {a, b, c, op, inv} bit-exact.
REQ-039 Assert async_reset_i low between clock edges while FULL -> outputs clear immediately, before the next edge.
